// File: rtl/conv2d_engine.sv
// KxK "valid" 2-D convolution engine that reads image and kernel from a single-port word memory
// and writes results back. Define CONV2D_SAT_EN to saturate results instead of wrapping them.
module conv2d_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] ker_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] mem_index,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned KK = K * K;
    localparam int unsigned NW = (KK > 1) ? $clog2(KK) : 1;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned AW = 2 * DATA_W + $clog2(KK);
    localparam logic [NW-1:0]    NLast  = NW'(KK - 1);
    localparam logic [NW-1:0]    NOne   = NW'(1);
    localparam logic [IW-1:0]    ILast  = IW'(K - 1);
    localparam logic [IW-1:0]    IOne   = IW'(1);
    localparam logic [DIM_W-1:0] KM1    = DIM_W'(K - 1);
    localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);
`ifdef CONV2D_SAT_EN
    localparam logic signed [AW-1:0] SatMax = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {StIdle, StKreq, StKcap, StPreq, StPcap, StWr, StDone} state_t;

    state_t                     state_q;
    logic [ADDR_W-1:0]          src_q, ker_q, dst_q;
    logic [DIM_W-1:0]           w_q, ow_q, oh_q;
    logic [DIM_W-1:0]           r_q, c_q;
    logic [IW-1:0]              i_q, j_q;
    logic [NW-1:0]              n_q;
    logic signed [AW-1:0]       acc_q;
    logic signed [DATA_W-1:0]   coef_q [KK];

    logic                       geom_bad, last_tap, last_col, last_pix;
    logic [IW-1:0]              ni, nj;
    logic [DIM_W-1:0]           nr, nc;
    logic [NW-1:0]              tap;
    logic [ADDR_W-1:0]          tap_addr, pix_addr, wr_addr;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [AW-1:0]       acc_sum, shifted;
    logic [DATA_W-1:0]          result;

    always_comb begin
        geom_bad = (32'(img_w) < K) || (32'(img_h) < K);
        last_tap = (i_q == ILast) && (j_q == ILast);
        last_col = (c_q == ow_q - DimOne);
        last_pix = last_col && (r_q == oh_q - DimOne);
        nj       = (j_q == ILast) ? '0 : j_q + IOne;
        ni       = (j_q == ILast) ? i_q + IOne : i_q;
        nc       = last_col ? '0 : c_q + DimOne;
        nr       = last_col ? r_q + DimOne : r_q;
        tap      = NW'(i_q * K + j_q);
        // All address terms are reduced to ADDR_W bits so the sums wrap silently.
        tap_addr = src_q + (ADDR_W'(r_q) + ADDR_W'(ni)) * ADDR_W'(w_q) + ADDR_W'(c_q)
                   + ADDR_W'(nj);
        pix_addr = src_q + ADDR_W'(nr) * ADDR_W'(w_q) + ADDR_W'(nc);
        wr_addr  = dst_q + ADDR_W'(r_q) * ADDR_W'(ow_q) + ADDR_W'(c_q);
        prod     = $signed(mem_out) * coef_q[tap];
        acc_sum  = acc_q + AW'(prod);
        shifted  = acc_sum >>> SHIFT;
`ifdef CONV2D_SAT_EN
        if (shifted > SatMax) begin
            result = DATA_W'(SatMax);
        end else if (shifted < SatMin) begin
            result = DATA_W'(SatMin);
        end else begin
            result = DATA_W'(shifted);
        end
`else
        result   = DATA_W'(shifted);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            src_q     <= '0;
            ker_q     <= '0;
            dst_q     <= '0;
            w_q       <= '0;
            ow_q      <= '0;
            oh_q      <= '0;
            r_q       <= '0;
            c_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            coef_q    <= '{default: '0};
            mem_index <= '0;
            mem_in    <= '0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q <= src_base;
                        ker_q <= ker_base;
                        dst_q <= dst_base;
                        w_q   <= img_w;
                        ow_q  <= img_w - KM1;
                        oh_q  <= img_h - KM1;
                        if (geom_bad) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            state_q   <= StKreq;
                            busy      <= 1'b1;
                            n_q       <= '0;
                            mem_index <= ker_base;
                        end
                    end
                end
                StKreq: state_q <= StKcap;
                StKcap: begin
                    coef_q[n_q] <= mem_out;
                    if (n_q == NLast) begin
                        state_q   <= StPreq;
                        r_q       <= '0;
                        c_q       <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                        acc_q     <= '0;
                        mem_index <= src_q;
                    end else begin
                        state_q   <= StKreq;
                        n_q       <= n_q + NOne;
                        mem_index <= ker_q + ADDR_W'(n_q + NOne);
                    end
                end
                StPreq: state_q <= StPcap;
                StPcap: begin
                    acc_q <= acc_sum;
                    if (last_tap) begin
                        state_q   <= StWr;
                        mem_wr    <= 1'b1;
                        mem_in    <= result;
                        mem_index <= wr_addr;
                    end else begin
                        state_q   <= StPreq;
                        i_q       <= ni;
                        j_q       <= nj;
                        mem_index <= tap_addr;
                    end
                end
                StWr: begin
                    mem_wr <= 1'b0;
                    if (last_pix) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_q   <= StPreq;
                        r_q       <= nr;
                        c_q       <= nc;
                        i_q       <= '0;
                        j_q       <= '0;
                        acc_q     <= '0;
                        mem_index <= pix_addr;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine: one instance with SHIFT=0, one with SHIFT=2, sharing a
// behavioural single-port memory selected by sel.
module tb_conv2d_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start2 = 1'b0, sel = 1'b0;
    logic [8:0]  src_base = '0, ker_base = '0, dst_base = '0;
    logic [7:0]  img_w = '0, img_h = '0;
    logic [31:0] mem_out;
    logic [8:0]  idx0, idx2, m_idx;
    logic [31:0] in0, in2, m_in;
    logic        wr0, wr2, m_wr, busy0, busy2, busy_s, done0, done2, done_s, err0, err2, err_s;
    logic        tb_we = 1'b0;
    logic [8:0]  tb_addr = '0;
    logic [31:0] tb_data = '0;
    logic [31:0] mem [512];

    int errors = 0;
    int checks = 0;
    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];
    int bc, dc;
    bit es, ds, da, ba;

    always #5 clk = ~clk;

    conv2d_engine #(.DATA_W(32), .ADDR_W(9), .DIM_W(8), .K(3), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .src_base(src_base), .ker_base(ker_base),
        .dst_base(dst_base), .img_w(img_w), .img_h(img_h), .mem_out(mem_out),
        .mem_index(idx0), .mem_in(in0), .mem_wr(wr0), .busy(busy0), .done(done0), .err(err0)
    );

    conv2d_engine #(.DATA_W(32), .ADDR_W(9), .DIM_W(8), .K(3), .SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .src_base(src_base), .ker_base(ker_base),
        .dst_base(dst_base), .img_w(img_w), .img_h(img_h), .mem_out(mem_out),
        .mem_index(idx2), .mem_in(in2), .mem_wr(wr2), .busy(busy2), .done(done2), .err(err2)
    );

    assign m_idx  = sel ? idx2 : idx0;
    assign m_in   = sel ? in2 : in0;
    assign m_wr   = sel ? wr2 : wr0;
    assign busy_s = sel ? busy2 : busy0;
    assign done_s = sel ? done2 : done0;
    assign err_s  = sel ? err2 : err0;

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (m_wr) mem[m_idx] <= m_in;
        mem_out <= mem[m_idx];
    end

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = 9'(a); tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic fill(input int base, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) poke(base + k, d);
    endtask

    // Launches a job and records writes; stray>0 injects a start with other bases at that cycle.
    task automatic run_job(input bit s, input int src, input int ker, input int dst,
                           input int w, input int h, input int stray,
                           output int busy_cnt, output int done_cyc, output bit err_seen,
                           output bit done_seen, output bit done_after, output bit busy_after);
        obs_q.delete();
        @(negedge clk);
        sel = s; src_base = 9'(src); ker_base = 9'(ker); dst_base = 9'(dst);
        img_w = 8'(w); img_h = 8'(h);
        if (s) start2 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start2 = 1'b0;
        busy_cnt = 0; done_cyc = 0; err_seen = 1'b0; done_seen = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
            if (busy_s) busy_cnt++;
            if (m_wr) obs_q.push_back({m_idx, m_in});
            if (done_s) begin
                done_seen = 1'b1; err_seen = err_s; done_cyc = cyc;
            end
            if (cyc == stray) begin
                src_base = 9'd200; ker_base = 9'd300; dst_base = 9'd400;
                img_w = 8'd5; img_h = 8'd5;
                if (s) start2 = 1'b1; else start0 = 1'b1;
            end
            if (cyc == stray + 1) begin
                start0 = 1'b0; start2 = 1'b0;
            end
            if (!done_seen) @(negedge clk);
        end
        @(negedge clk);
        done_after = done_s; busy_after = busy_s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (idx0 !== 9'd0) begin errors++; $display("FAIL reset mem_index got %h want 0", idx0); end
        checks++; if (in0 !== 32'd0) begin errors++; $display("FAIL reset mem_in got %h want 0", in0); end
        checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL reset mem_wr got %b want 0", wr0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset err got %b want 0", err0); end
        rst = 1'b0;
    endtask

    task automatic test_all_ones();
        logic [40:0] e, o;
        fill(0, 16, 32'd1);
        fill(16, 9, 32'd1);
        for (int k = 0; k < 4; k++) exp_q.push_back({9'(100 + k), 32'd9});
        run_job(1'b0, 0, 16, 100, 4, 4, 0, bc, dc, es, ds, da, ba);
        checks++; if (!ds) begin errors++; $display("FAIL all_ones done got 0 want 1"); end
        checks++; if (bc != 94) begin errors++; $display("FAIL all_ones busy_cycles got %0d want 94", bc); end
        checks++; if (es !== 1'b0) begin errors++; $display("FAIL all_ones err got %b want 0", es); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL all_ones done_width got %b want 0", da); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL all_ones writes got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL all_ones write got %0d:%h want %0d:%h", o[40:32], o[31:0], e[40:32], e[31:0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_ramp();
        logic [40:0] e, o;
        for (int k = 0; k < 25; k++) poke(k, 32'(k));
        for (int k = 0; k < 9; k++) poke(40 + k, (k == 4) ? 32'd1 : 32'd0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back({9'(60 + r * 3 + c), 32'((r + 1) * 5 + c + 1)});
        run_job(1'b0, 0, 40, 60, 5, 5, 0, bc, dc, es, ds, da, ba);
        checks++; if (bc != 18 + 9 * 19) begin errors++; $display("FAIL ramp busy_cycles got %0d want %0d", bc, 18 + 9 * 19); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ramp writes got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL ramp write got %0d:%h want %0d:%h", o[40:32], o[31:0], e[40:32], e[31:0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_bad_geom();
        run_job(1'b0, 0, 16, 100, 2, 5, 0, bc, dc, es, ds, da, ba);
        checks++; if (!ds || dc != 1) begin errors++; $display("FAIL bad_geom done_cycle got %0d want 1", dc); end
        checks++; if (es !== 1'b1) begin errors++; $display("FAIL bad_geom err got %b want 1", es); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bad_geom writes got %0d want 0", obs_q.size()); end
        checks++; if (bc != 0) begin errors++; $display("FAIL bad_geom busy_cycles got %0d want 0", bc); end
        checks++; if (da !== 1'b0 || ba !== 1'b0) begin
            errors++; $display("FAIL bad_geom after got done=%b busy=%b want 0 0", da, ba);
        end
    endtask

    task automatic test_saturation();
        logic [40:0] e, o;
        fill(0, 9, 32'h7FFF_FFFF);
        fill(16, 9, 32'd1);
`ifdef CONV2D_SAT_EN
        exp_q.push_back({9'd100, 32'h7FFF_FFFF});
`else
        exp_q.push_back({9'd100, 32'h7FFF_FFF7});
`endif
        run_job(1'b0, 0, 16, 100, 3, 3, 0, bc, dc, es, ds, da, ba);
        checks++; if (bc != 18 + 19) begin errors++; $display("FAIL sat busy_cycles got %0d want 37", bc); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL sat writes got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL sat write got %0d:%h want %0d:%h", o[40:32], o[31:0], e[40:32], e[31:0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_ignore_start();
        logic [40:0] e, o;
        fill(0, 16, 32'd1);
        for (int k = 0; k < 4; k++) exp_q.push_back({9'(100 + k), 32'd9});
        run_job(1'b0, 0, 16, 100, 4, 4, 30, bc, dc, es, ds, da, ba);
        checks++; if (bc != 94) begin errors++; $display("FAIL ignore_start busy_cycles got %0d want 94", bc); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ignore_start writes got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL ignore_start write got %0d:%h want %0d:%h", o[40:32], o[31:0], e[40:32], e[31:0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_abort();
        logic [40:0] e, o;
        int n_done, n_wr;
        @(negedge clk);
        sel = 1'b0; src_base = 9'd0; ker_base = 9'd16; dst_base = 9'd100;
        img_w = 8'd4; img_h = 8'd4; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (wr0 !== 1'b0) begin errors++; $display("FAIL abort mem_wr got %b want 0", wr0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort busy got %b want 0", busy0); end
        rst = 1'b0;
        n_done = (done0 === 1'b1) ? 1 : 0;
        n_wr = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (done0 === 1'b1) n_done++;
            if (wr0 === 1'b1) n_wr++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL abort done_pulses got %0d want 0", n_done); end
        checks++; if (n_wr != 0) begin errors++; $display("FAIL abort idle_writes got %0d want 0", n_wr); end
        for (int k = 0; k < 4; k++) exp_q.push_back({9'(100 + k), 32'd9});
        run_job(1'b0, 0, 16, 100, 4, 4, 0, bc, dc, es, ds, da, ba);
        checks++; if (bc != 94) begin errors++; $display("FAIL restart busy_cycles got %0d want 94", bc); end
        checks++; if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL restart writes got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin
                errors++; $display("FAIL restart write got %0d:%h want %0d:%h", o[40:32], o[31:0], e[40:32], e[31:0]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_shift();
        logic [40:0] e, o;
        fill(0, 16, 32'd1);
        for (int pass = 0; pass < 2; pass++) begin
            fill(16, 9, (pass == 0) ? 32'd3 : -32'sd3);
            for (int k = 0; k < 4; k++)
                exp_q.push_back({9'(100 + k), (pass == 0) ? 32'd6 : 32'hFFFF_FFF9});
            run_job(1'b1, 0, 16, 100, 4, 4, 0, bc, dc, es, ds, da, ba);
            checks++; if (bc != 94) begin errors++; $display("FAIL shift busy_cycles got %0d want 94", bc); end
            checks++; if (obs_q.size() != exp_q.size()) begin
                errors++; $display("FAIL shift writes got %0d want %0d", obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
                if (o !== e) begin
                    errors++; $display("FAIL shift write got %0d:%h want %0d:%h", o[40:32], o[31:0], e[40:32], e[31:0]);
                end
            end
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_ramp();
        test_bad_geom();
        test_saturation();
        test_ignore_start();
        test_reset_abort();
        test_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
